// File: rtl/int_ctrl18_pkg.sv
// Shared definitions for the Core18 interrupt controller: register offsets,
// controller state encoding and the priority encoder used to pick a vector.
package int18_pkg;

   localparam logic [2:0] REG_PENDING = 3'd0;
   localparam logic [2:0] REG_MASK    = 3'd1;
   localparam logic [2:0] REG_EDGE    = 3'd2;
   localparam logic [2:0] REG_CURRENT = 3'd3;
   localparam logic [2:0] REG_SWINT   = 3'd4;

   localparam logic [3:0] VECTOR_NONE = 4'd0;
   localparam int         MAX_IRQ     = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   // Vector of the highest set line (line i -> vector i+1), 0 when none set.
   function automatic logic [3:0] highest_vector(input logic [14:0] act);
      logic [3:0] v;
      v = VECTOR_NONE;
      for (int i = 0; i < MAX_IRQ; i++) begin
         if (act[i]) v = 4'(i + 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/int_ctrl18_if.sv
// Core18 port bus as seen by a peripheral: strobes, address, write data in,
// read data and select back to the core's DATAIN mux.
interface int_ctrl18_if;

   logic        PORT_RD;
   logic        PORT_WR;
   logic [17:0] ADRS;
   logic [17:0] WDATA;
   logic [17:0] RDATA;
   logic        SEL;

   modport master (output PORT_RD, PORT_WR, ADRS, WDATA, input RDATA, SEL);
   modport slave  (input PORT_RD, PORT_WR, ADRS, WDATA, output RDATA, SEL);

endinterface

// File: rtl/int_ctrl18_sync.sv
// One request line: multi-flop synchroniser plus a single-cycle rising-edge
// pulse taken between the last sync stage and one extra delayed flop.
module irq_sync18 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [SYNC_STAGES-1:0] stage_reg;
   logic                   prev_reg;

   // Shift the asynchronous line through the sync chain; keep last value for edge detect.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stage_reg <= '0;
         prev_reg  <= 1'b0;
      end else begin
         stage_reg <= {stage_reg[SYNC_STAGES-2:0], async_in};
         prev_reg  <= stage_reg[SYNC_STAGES-1];
      end
   end

   assign sync_out = stage_reg[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_reg;

endmodule

// File: rtl/int_ctrl18.sv
// Interrupt controller for Core18: per-line edge/level pending latches,
// software mask, and a registered priority vector held until EOI.
module int_ctrl18
   import int18_pkg::*;
#(
   parameter int          NUM_IRQ     = 15,
   parameter logic [17:0] ADRS_BASE   = 18'o000100,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [14:0]      IRQ,
   int_ctrl18_if.slave      bus,
   output logic [3:0]       VECTOR
);

   logic [14:0] sync_line;
   logic [14:0] rise_line;
   logic [14:0] pending_reg, pending_next;
   logic [14:0] mask_reg;
   logic [14:0] edge_reg;
   logic [14:0] active;
   logic [3:0]  best;
   logic [3:0]  vector_reg, vector_next;
   state_t      state_reg, state_next;
   logic        cur_active;

   logic [17:0] offset_full;
   logic [2:0]  offset;
   logic        sel;
   logic [17:0] rdata;
   logic        wr_pending, wr_mask, wr_edge, wr_current, wr_swint;
   logic        unused_bits;

   // Address decode: the block owns eight consecutive words from ADRS_BASE.
   assign offset_full = bus.ADRS - ADRS_BASE;
   assign sel         = (bus.ADRS >= ADRS_BASE) && (offset_full < 18'd8);
   assign offset      = offset_full[2:0];

   assign wr_pending = bus.PORT_WR && sel && (offset == REG_PENDING);
   assign wr_mask    = bus.PORT_WR && sel && (offset == REG_MASK);
   assign wr_edge    = bus.PORT_WR && sel && (offset == REG_EDGE);
   assign wr_current = bus.PORT_WR && sel && (offset == REG_CURRENT);
   assign wr_swint   = bus.PORT_WR && sel && (offset == REG_SWINT);

   // Reads have no side effects, so the read strobe is not needed for decode.
   assign unused_bits = ^{bus.PORT_RD, bus.WDATA[17:15]};

   generate
      for (genvar gi = 0; gi < MAX_IRQ; gi++) begin : g_line
         if (gi < NUM_IRQ) begin : g_used
            logic set_bit;
            logic clr_bit;

            irq_sync18 #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
               .CLK      (CLK),
               .RESET    (RESET),
               .async_in (IRQ[gi]),
               .sync_out (sync_line[gi]),
               .rise     (rise_line[gi])
            );

            // Set sources win over clear sources arriving in the same cycle.
            assign set_bit = rise_line[gi] | (wr_swint & bus.WDATA[gi]);
            assign clr_bit = (wr_pending & bus.WDATA[gi]) |
                             (wr_current & (vector_reg == 4'(gi + 1)));
            assign pending_next[gi] = !edge_reg[gi] ? sync_line[gi] :
                                      set_bit       ? 1'b1 :
                                      clr_bit       ? 1'b0 : pending_reg[gi];
         end else begin : g_unused
            assign sync_line[gi]    = 1'b0;
            assign rise_line[gi]    = 1'b0;
            assign pending_next[gi] = 1'b0;
         end
      end
   endgenerate

   // Pending latches and the software-programmed mask/edge registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending_reg <= '0;
         mask_reg    <= '0;
         edge_reg    <= '1;
      end else begin
         pending_reg <= pending_next;
         if (wr_mask) mask_reg <= bus.WDATA[14:0];
         if (wr_edge) edge_reg <= bus.WDATA[14:0];
      end
   end

   assign active = pending_reg & mask_reg;
   assign best   = highest_vector(active);

   // Controller state and registered vector.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg  <= IDLE;
         vector_reg <= VECTOR_NONE;
      end else begin
         state_reg  <= state_next;
         vector_reg <= vector_next;
      end
   end

   // Next state: present, pre-empt with higher priority, or drop to a one-cycle gap.
   always_comb begin
      state_next  = state_reg;
      vector_next = vector_reg;
      cur_active  = 1'b0;
      for (int i = 0; i < MAX_IRQ; i++) begin
         if ((vector_reg == 4'(i + 1)) && active[i]) cur_active = 1'b1;
      end
      case (state_reg)
         IDLE: begin
            vector_next = VECTOR_NONE;
            if (active != '0) begin
               state_next  = PRESENT;
               vector_next = best;
            end
         end
         PRESENT: begin
            if (!cur_active) begin
               state_next  = GAP;
               vector_next = VECTOR_NONE;
            end else if (best > vector_reg) begin
               vector_next = best;
            end
         end
         GAP: begin
            state_next  = IDLE;
            vector_next = VECTOR_NONE;
         end
         default: begin
            state_next  = IDLE;
            vector_next = VECTOR_NONE;
         end
      endcase
   end

   // Register read mux; zero whenever the address is outside the block.
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (offset)
            REG_PENDING: rdata = {3'b0, pending_reg};
            REG_MASK:    rdata = {3'b0, mask_reg};
            REG_EDGE:    rdata = {3'b0, edge_reg};
            REG_CURRENT: rdata = {14'b0, vector_reg};
            default:     rdata = '0;
         endcase
      end
   end

   assign bus.RDATA = rdata;
   assign bus.SEL   = sel;
   assign VECTOR    = vector_reg;

endmodule
